// File: rtl/read_port_dispatcher_if.sv
// Stream interface for read_port_dispatcher: SRAM-side word input and the shared
// one-hot-qualified output bus.
interface read_port_dispatcher_if #(
    parameter int unsigned NUM_PORTS  = 16,
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [3:0]            in_dest;
    logic                  in_sop;
    logic                  in_eop;

    logic [NUM_PORTS-1:0]  out_valid;
    logic [NUM_PORTS-1:0]  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sop;
    logic                  out_eop;

    modport slave (
        input  in_valid, in_data, in_dest, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );

    modport master (
        output in_valid, in_data, in_dest, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/read_port_dispatcher.sv
// Routes SRAM read packets to one of 16 output ports through a 2-entry buffer.
// Optional macro PKT_LEN_CHECK_EN enables the MAX_PKT_WORDS packet length limit.
module read_port_dispatcher #(
    parameter int unsigned NUM_PORTS     = 16,
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned MAX_PKT_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    read_port_dispatcher_if.slave    bus,
    output logic                     busy,
    output logic [3:0]               cur_dest,
    output logic [7:0]               drop_cnt,
    output logic                     proto_err
);

    typedef enum logic [0:0] {StIdle, StXfer} state_t;

    state_t                r_state, w_state_d;
    logic [DATA_WIDTH-1:0] r_data [2];
    logic [3:0]            r_dest [2];
    logic [1:0]            r_sop;
    logic [1:0]            r_eop;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [1:0]            w_count_d;
    logic                  r_in_ready;
    logic [3:0]            r_cur_dest, w_cur_dest_d;
    logic [7:0]            r_drop_cnt;
    logic                  r_proto_err;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_err;
    logic [3:0]            w_push_dest;
    logic                  w_push_eop;
    logic                  w_view;

`ifdef PKT_LEN_CHECK_EN
    localparam int unsigned LenW = $clog2(MAX_PKT_WORDS + 1);
    logic [LenW-1:0]       r_len, w_len_d;
`else
    logic                  w_unused_len_cfg;
    assign w_unused_len_cfg = ^MAX_PKT_WORDS;
`endif

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_pop    = (r_count != 2'd0) && bus.out_ready[r_dest[r_rptr]];

    always_comb begin
        w_state_d    = r_state;
        w_cur_dest_d = r_cur_dest;
        w_push       = 1'b0;
        w_push_dest  = r_cur_dest;
        w_push_eop   = bus.in_eop;
        w_drop       = 1'b0;
        w_err        = 1'b0;
`ifdef PKT_LEN_CHECK_EN
        w_len_d      = r_len;
`endif
        if (w_accept) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_sop) begin
                        w_push       = 1'b1;
                        w_push_dest  = bus.in_dest;
                        w_cur_dest_d = bus.in_dest;
                        if (!bus.in_eop) w_state_d = StXfer;
                    end else begin
                        w_drop = 1'b1;
                        w_err  = 1'b1;
                    end
                end
                StXfer: begin
                    w_push = 1'b1;
                    // A sop here means the previous packet lost its eop: restart on the new dest.
                    if (bus.in_sop) begin
                        w_push_dest  = bus.in_dest;
                        w_cur_dest_d = bus.in_dest;
                        w_err        = 1'b1;
                    end
                    if (bus.in_eop) w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
`ifdef PKT_LEN_CHECK_EN
            if (w_push) begin
                w_len_d = bus.in_sop ? LenW'(1) : r_len + LenW'(1);
                if (!bus.in_eop && (w_len_d >= LenW'(MAX_PKT_WORDS))) begin
                    w_push_eop = 1'b1;
                    w_err      = 1'b1;
                    w_state_d  = StIdle;
                end
            end
`endif
        end
    end

    assign w_count_d = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // With an empty buffer the slot behind the read pointer is the last word popped.
    assign w_view = (r_count != 2'd0) ? r_rptr : ~r_rptr;

    always_comb begin
        bus.out_valid = '0;
        if (r_count != 2'd0) bus.out_valid[r_dest[r_rptr]] = 1'b1;
    end

    assign bus.out_data = r_data[w_view];
    assign bus.out_sop  = r_sop[w_view];
    assign bus.out_eop  = r_eop[w_view];
    assign bus.in_ready = r_in_ready;

    assign busy      = (r_state == StXfer);
    assign cur_dest  = r_cur_dest;
    assign drop_cnt  = r_drop_cnt;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_data[0]   <= '0;
            r_data[1]   <= '0;
            r_dest[0]   <= '0;
            r_dest[1]   <= '0;
            r_sop       <= '0;
            r_eop       <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_cur_dest  <= '0;
            r_drop_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cur_dest  <= w_cur_dest_d;
            r_count     <= w_count_d;
            r_in_ready  <= (w_count_d != 2'd2);
            r_proto_err <= w_err;
            if (w_push) begin
                r_data[r_wptr] <= bus.in_data;
                r_dest[r_wptr] <= w_push_dest;
                r_sop[r_wptr]  <= bus.in_sop;
                r_eop[r_wptr]  <= w_push_eop;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef PKT_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_len <= '0;
        else      r_len <= w_len_d;
    end
`endif

endmodule

// File: tb/tb_read_port_dispatcher.sv
// Scoreboard bench for read_port_dispatcher: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_read_port_dispatcher;

    localparam int unsigned NP     = 16;
    localparam int unsigned DW     = 256;
    localparam int unsigned MaxPkt = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    dest;
        logic          sop;
        logic          eop;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_port_dispatcher_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    logic       busy;
    logic [3:0] cur_dest;
    logic [7:0] drop_cnt;
    logic       proto_err;

    read_port_dispatcher #(
        .NUM_PORTS    (NP),
        .DATA_WIDTH   (DW),
        .MAX_PKT_WORDS(MaxPkt)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .cur_dest (cur_dest),
        .drop_cnt (drop_cnt),
        .proto_err(proto_err)
    );

    logic          rand_mode = 1'b0;
    logic [NP-1:0] ready_val = '1;
    logic [NP-1:0] ready_rnd = '1;
    assign bus.out_ready = rand_mode ? ready_rnd : ready_val;
    always @(posedge clk) begin
        #1 ready_rnd = NP'($urandom);
    end

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: packet-level view of what should reach the ports.
    word_t q[$];
    int    m_in_pkt = 0;
    int    m_len    = 0;
    int    m_drops  = 0;
    logic [3:0] m_dest = '0;
    logic  exp_perr = 1'b0;
    int    warm     = 0;
    word_t m_last   = '0;

    function automatic void model_word(logic [DW-1:0] d, logic [3:0] dst, logic s, logic e);
        word_t w;
        logic  eop_eff;
        if (m_in_pkt == 0 && !s) begin
            if (m_drops < 255) m_drops++;
            exp_perr = 1'b1;
            return;
        end
        if (s) begin
            if (m_in_pkt != 0) exp_perr = 1'b1;
            m_dest = dst;
            m_len  = 0;
        end
        m_len++;
        eop_eff = e;
`ifdef PKT_LEN_CHECK_EN
        if (!e && m_len >= int'(MaxPkt)) begin
            eop_eff  = 1'b1;
            exp_perr = 1'b1;
        end
`endif
        w.data = d;
        w.dest = m_dest;
        w.sop  = s;
        w.eop  = eop_eff;
        q.push_back(w);
        m_in_pkt = eop_eff ? 0 : 1;
    endfunction

    // Sample the handshake away from the edge; apply it to the model on the edge.
    logic          s_acc = 1'b0;
    logic [DW-1:0] s_data;
    logic [3:0]    s_dest;
    logic          s_sop, s_eop;

    always @(negedge clk) begin
        s_acc  = rst && bus.in_valid && bus.in_ready;
        s_data = bus.in_data;
        s_dest = bus.in_dest;
        s_sop  = bus.in_sop;
        s_eop  = bus.in_eop;
    end

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_in_pkt = 0;
            m_len    = 0;
            m_drops  = 0;
            m_dest   = '0;
            exp_perr = 1'b0;
            warm     = 0;
        end else begin
            if (warm < 10) warm++;
            exp_perr = 1'b0;
            if (s_acc) model_word(s_data, s_dest, s_sop, s_eop);
        end
    end

    // Monitor: compares the presented head word and status every cycle.
    always @(negedge clk) begin
        word_t h;
        int    occ;
        if (!rst) begin
            m_last = '0;
            chk("reset_outs", {bus.out_valid, bus.in_ready, busy, drop_cnt, proto_err}, '0);
        end else begin
            occ = q.size();
            if (occ != 0) begin
                h = q[0];
                chk("out_word", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop},
                    {NP'(1) << h.dest, h.data, h.sop, h.eop});
                if (bus.out_ready[h.dest]) begin
                    m_last = h;
                    void'(q.pop_front());
                end
            end else begin
                chk("out_idle", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop},
                    {NP'(0), m_last.data, m_last.sop, m_last.eop});
            end
            if (warm != 0) chk("in_ready", bus.in_ready, (occ < 2));
            chk("status", {busy, cur_dest, drop_cnt, proto_err},
                {(m_in_pkt != 0), m_dest, 8'(m_drops), exp_perr});
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [3:0] dst, input logic s,
                        input logic e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dest  = dst;
        bus.in_sop   = s;
        bus.in_eop   = e;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        idle(2);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        chk("rst_immediate", {bus.out_valid, bus.in_ready, busy}, '0);
        idle(3);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        int len;
        logic s, e;
        logic [3:0] dst;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dest  = '0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);

        send(DW'(8'hA1), 4'd5, 1'b1, 1'b0);
        send(DW'(8'hA2), 4'd5, 1'b0, 1'b0);
        send(DW'(8'hA3), 4'd5, 1'b0, 1'b1);
        idle(3);

        send(rnd_word(), 4'd15, 1'b1, 1'b1);
        idle(3);

        ready_val = 16'hFFFB;
        send(rnd_word(), 4'd2, 1'b1, 1'b0);
        send(rnd_word(), 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_out_valid", bus.out_valid, 16'h0004);
        idle(2);
        ready_val = '1;
        send(rnd_word(), 4'd2, 1'b0, 1'b0);
        send(rnd_word(), 4'd2, 1'b0, 1'b1);
        idle(4);

        send(rnd_word(), 4'd9, 1'b0, 1'b0);
        idle(2);
        chk("drop_one", drop_cnt, 8'd1);
        repeat (300) send(rnd_word(), 4'($urandom), 1'b0, 1'b0);
        idle(2);
        chk("drop_sat", drop_cnt, 8'd255);

        send(rnd_word(), 4'd7, 1'b1, 1'b0);
        send(rnd_word(), 4'd7, 1'b0, 1'b0);
        send(rnd_word(), 4'd3, 1'b1, 1'b0);
        send(rnd_word(), 4'd7, 1'b0, 1'b0);
        send(rnd_word(), 4'd0, 1'b0, 1'b1);
        idle(3);

        ready_val = '0;
        send(rnd_word(), 4'd6, 1'b1, 1'b0);
        send(rnd_word(), 4'd6, 1'b0, 1'b0);
        pulse_reset();
        ready_val = '1;
        send(rnd_word(), 4'd1, 1'b1, 1'b0);
        send(rnd_word(), 4'd1, 1'b0, 1'b0);
        send(rnd_word(), 4'd1, 1'b0, 1'b1);
        idle(4);

        rand_mode = 1'b1;
        repeat (300) begin
            len = int'($urandom_range(1, 6));
            dst = 4'($urandom);
            for (int i = 0; i < len; i++) begin
                s = (i == 0);
                e = (i == len - 1);
                if ($urandom_range(0, 99) < 4) s = ~s;
                send(rnd_word(), s ? dst : 4'($urandom), s, e);
            end
            idle(int'($urandom_range(0, 2)));
        end
        rand_mode = 1'b0;
        drain();

`ifdef PKT_LEN_CHECK_EN
        pulse_reset();
        for (int i = 0; i < 6; i++) send(rnd_word(), 4'd10, (i == 0), (i == 5));
        idle(4);
        chk("len_drops", drop_cnt, 8'd2);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
